// File: rtl/attn_pkg.sv
// Shared definitions for the attention DMA sequencer: FSM state encoding,
// weight block sizing and default head count.
package attn_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WK_LD,
    S_K_CMP,
    S_K_XFER,
    S_WQ_LD,
    S_Q_CMP,
    S_Q_XFER,
    S_QK_WAIT,
    S_S_XFER,
    S_SMAX,
    S_DONE,
    S_ERR
  } seq_state_t;

  localparam int DMODEL            = 512;
  localparam int D_K               = 64;
  localparam int CIM_DATA_WIDTH    = 128;
  localparam int NUM_HEADS_DEFAULT = 32;

  function automatic int weight_bytes(input int dmodel, input int dk, input int dw);
    return (dmodel * dk * dw) / 8;
  endfunction

  localparam int WEIGHT_BYTES_DEFAULT = weight_bytes(DMODEL, D_K, CIM_DATA_WIDTH);

  // Phases in which the sequencer is actively waiting on a unit.
  function automatic logic phase_active(input seq_state_t s);
    return !(s inside {S_IDLE, S_DONE, S_ERR});
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-phase stall counter: cleared on every phase entry, counts waiting
// cycles and flags the cycle in which the count reaches its all-ones limit.
module seq_watchdog #(
  parameter int TIMEOUT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX  = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = CNT_MAX - TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] count_reg;

  // The increment made in the expiring cycle is the one that reaches CNT_MAX.
  assign expire = en && (count_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + TIMEOUT_W'(1);
    end
  end

endmodule

// File: rtl/attn_dma_seq.sv
// Attention DMA sequencer: walks every head through K load/compute/transfer,
// Q load/compute/transfer, QK score transfer and softmax.
module attn_dma_seq
  import attn_pkg::*;
#(
  parameter int BUS_ADDR_WIDTH = 32,
  parameter int NUM_HEADS      = NUM_HEADS_DEFAULT,
  parameter int HEAD_W         = 5,
  parameter int WEIGHT_BYTES   = WEIGHT_BYTES_DEFAULT,
  parameter int TIMEOUT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [BUS_ADDR_WIDTH-1:0] weight_base,
  input  logic [31:0]               seq_len,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [HEAD_W-1:0]         head_idx,
  output logic [BUS_ADDR_WIDTH-1:0] weight_address,
  output logic [31:0]               sequence_length,
  output logic                      en_weight_dma,
  output logic                      en_loadk_dma,
  output logic                      en_loadq_dma,
  output logic                      en_loadscore_dma,
  input  logic                      done_weight_dma,
  input  logic                      done_loadq_dma,
  input  logic                      done_loadscore_dma,
  input  logic                      k_load_done,
  output logic                      cim_start,
  input  logic                      cim_done,
  input  logic                      qk_done,
  output logic                      smax_start,
  input  logic                      smax_done
);

  localparam logic [BUS_ADDR_WIDTH-1:0] WB_C   = BUS_ADDR_WIDTH'(WEIGHT_BYTES);
  localparam logic [HEAD_W-1:0]         H_LAST = HEAD_W'(NUM_HEADS - 1);

  seq_state_t                state_reg, state_next;
  logic [HEAD_W-1:0]         h_reg, h_next;
  logic [BUS_ADDR_WIDTH-1:0] base_reg, base_next;
  logic [BUS_ADDR_WIDTH-1:0] blk_idx;
  logic [BUS_ADDR_WIDTH-1:0] addr_next;
  logic                      launch;
  logic                      wd_clr, wd_en, wd_expire;

  assign launch   = (state_reg == S_IDLE) && start && !abort;
  assign head_idx = h_reg;

  always_comb begin
    state_next = state_reg;
    h_next     = h_reg;
    base_next  = base_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          base_next  = weight_base;
          h_next     = '0;
          state_next = (seq_len == 32'd0) ? S_ERR : S_WK_LD;
        end
      end
      S_WK_LD:   if (done_weight_dma)    state_next = S_K_CMP;
      S_K_CMP:   if (cim_done)           state_next = S_K_XFER;
      S_K_XFER:  if (k_load_done)        state_next = S_WQ_LD;
      S_WQ_LD:   if (done_weight_dma)    state_next = S_Q_CMP;
      S_Q_CMP:   if (cim_done)           state_next = S_Q_XFER;
      S_Q_XFER:  if (done_loadq_dma)     state_next = S_QK_WAIT;
      S_QK_WAIT: if (qk_done)            state_next = S_S_XFER;
      S_S_XFER:  if (done_loadscore_dma) state_next = S_SMAX;
      S_SMAX: begin
        if (smax_done) begin
          if (h_reg == H_LAST) begin
            state_next = S_DONE;
          end else begin
            h_next     = h_reg + HEAD_W'(1);
            state_next = S_WK_LD;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
    // A completion in the expiring cycle still wins over the timeout.
    if (wd_expire && (state_next == state_reg)) begin
      state_next = S_ERR;
    end
    if (abort) begin
      state_next = S_IDLE;
      h_next     = '0;
    end
  end

  // Weight block index is 2*h for K and 2*h+1 for Q; arithmetic wraps at bus width.
  always_comb begin
    blk_idx   = BUS_ADDR_WIDTH'({h_next, (state_next == S_WQ_LD)});
    addr_next = weight_address;
    if ((state_next == S_WK_LD) || (state_next == S_WQ_LD)) begin
      addr_next = base_next + blk_idx * WB_C;
    end
  end

  assign wd_clr = (state_next != state_reg);
  assign wd_en  = phase_active(state_reg);

  seq_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      h_reg     <= '0;
      base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      h_reg     <= h_next;
      base_reg  <= base_next;
    end
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      weight_address   <= '0;
      sequence_length  <= '0;
      en_weight_dma    <= 1'b0;
      en_loadk_dma     <= 1'b0;
      en_loadq_dma     <= 1'b0;
      en_loadscore_dma <= 1'b0;
      cim_start        <= 1'b0;
      smax_start       <= 1'b0;
    end else begin
      if (launch) begin
        sequence_length <= seq_len;
      end
      busy             <= phase_active(state_next);
      done             <= (state_next == S_DONE);
      error            <= (state_next == S_ERR);
      weight_address   <= addr_next;
      en_weight_dma    <= (state_next == S_WK_LD) || (state_next == S_WQ_LD);
      en_loadk_dma     <= (state_next == S_K_XFER);
      en_loadq_dma     <= (state_next == S_Q_XFER);
      en_loadscore_dma <= (state_next == S_S_XFER);
      cim_start        <= ((state_next == S_K_CMP) || (state_next == S_Q_CMP)) &&
                          (state_next != state_reg);
      smax_start       <= (state_next == S_SMAX) && (state_reg != S_SMAX);
    end
  end

endmodule
